// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the banked SRAM controller.
//
// Contents:
//   BANK_IDX_W   - fixed width of the bank index carried through the read pipeline
//   clog2()      - ceiling log2 usable in parameter expressions
//   nbanks()     - number of SRAM macros for a given total/per-macro address width
//   be_width()   - number of byte enables for a given data width
//   pipe_entry_t - one stage of the read-latency pipeline {valid, bank}
package sram_ctrl_pkg;

    // Wide enough for up to 256 banks. The top rejects configurations that need more.
    localparam int BANK_IDX_W = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int nbanks(input int addr_width, input int bank_addr_width);
        return 1 << (addr_width - bank_addr_width);
    endfunction

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [BANK_IDX_W-1:0] bank;
    } pipe_entry_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Response FIFO for the banked SRAM controller.
//
// Holds up to DEPTH read words in order. The head word sits in a dedicated
// output register, so out_valid/out_data come straight from flops. The word
// behind it waits in a small ring buffer. Push and pop may happen in the same
// cycle at any occupancy.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_data this cycle
//   push_data  - word to enqueue
//   pop_ready  - consumer takes the head word when out_valid is also high
//   out_valid  - head word present
//   out_data   - head word; held while out_valid && !pop_ready
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] ring [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      ring_count;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic pop;
    logic out_free;
    logic ring_empty;
    logic load_from_ring;
    logic load_from_push;
    logic ring_write;

    assign pop        = out_valid_q && pop_ready;
    assign out_free   = !out_valid_q || pop;
    assign ring_empty = (ring_count == '0);

    // The output register refills from the ring first so that order is kept.
    // A push bypasses the ring only when the ring is empty.
    assign load_from_ring = out_free && !ring_empty;
    assign load_from_push = out_free && ring_empty && push;
    assign ring_write     = push && !load_from_push;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Output register, ring pointers and ring occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ring_count  <= '0;
        end else begin
            if (out_free) begin
                if (!ring_empty) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= ring[rd_ptr];
                end else if (push) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= push_data;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
            if (ring_write) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (load_from_ring) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            ring_count <= ring_count + CNT_W'(ring_write) - CNT_W'(load_from_ring);
        end
    end

    // Ring storage carries no reset. Stale words are never read because
    // ring_count gates every read.
    always_ff @(posedge clk) begin
        if (ring_write) begin
            ring[wr_ptr] <= push_data;
        end
    end

    // Total occupancy must never exceed DEPTH. Upstream read credits are
    // responsible for keeping it within that limit.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (CNT_W'(out_valid_q) + ring_count) == CNT_W'(DEPTH)));

endmodule

// File: rtl/sram_bank_ctrl.sv
// Banked SRAM controller.
//
// Accepts word reads and writes on a valid/ready request port and drives
// NBANKS SRAM macros that share address, data and mask buses. Each macro has
// its own enable, write-enable and read-enable. A READ_LATENCY-deep pipeline
// tracks in-flight reads. When a read reaches the end of the pipeline, the
// selected macro's DOUT is captured into a response FIFO. Read credits make
// sure every accepted read has a FIFO slot, so response back-pressure never
// drops data.
//
// Ports:
//   CLK, RST                      - clock, synchronous active-high reset
//   REQ_VALID/READY/WE/ADDR/WDATA/BE - request channel (BE used on writes only)
//   RSP_VALID/READY/RDATA         - read response channel
//   MEM_ADDR/DIN/BM               - broadcast macro address, write data, bit mask
//   MEM_MEN/WEN/REN               - per-bank enable, write enable, read enable
//   MEM_DOUT                      - concatenated macro outputs, bank b at [b*DATA_WIDTH +: DATA_WIDTH]
module sram_bank_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH      = 32,
    parameter  int ADDR_WIDTH      = 11,
    parameter  int BANK_ADDR_WIDTH = 10,
    parameter  int READ_LATENCY    = 1,
    parameter  int RSP_DEPTH       = 3,
    localparam int NBANKS          = nbanks(ADDR_WIDTH, BANK_ADDR_WIDTH),
    localparam int BE_WIDTH        = be_width(DATA_WIDTH)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic                         REQ_WE,
    input  logic [ADDR_WIDTH-1:0]        REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]        REQ_WDATA,
    input  logic [BE_WIDTH-1:0]          REQ_BE,
    output logic                         RSP_VALID,
    input  logic                         RSP_READY,
    output logic [DATA_WIDTH-1:0]        RSP_RDATA,
    output logic [BANK_ADDR_WIDTH-1:0]   MEM_ADDR,
    output logic [DATA_WIDTH-1:0]        MEM_DIN,
    output logic [DATA_WIDTH-1:0]        MEM_BM,
    output logic [NBANKS-1:0]            MEM_MEN,
    output logic [NBANKS-1:0]            MEM_WEN,
    output logic [NBANKS-1:0]            MEM_REN,
    input  logic [NBANKS*DATA_WIDTH-1:0] MEM_DOUT
);

    localparam int CREDIT_W = clog2(RSP_DEPTH + 1);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("sram_bank_ctrl: DATA_WIDTH must be a multiple of 8");
    end
    if (ADDR_WIDTH < BANK_ADDR_WIDTH) begin : g_bad_addr_width
        $error("sram_bank_ctrl: ADDR_WIDTH must be >= BANK_ADDR_WIDTH");
    end
    if (ADDR_WIDTH - BANK_ADDR_WIDTH > BANK_IDX_W) begin : g_too_many_banks
        $error("sram_bank_ctrl: too many banks for BANK_IDX_W");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("sram_bank_ctrl: READ_LATENCY must be >= 1");
    end
    if (RSP_DEPTH < 1) begin : g_bad_depth
        $error("sram_bank_ctrl: RSP_DEPTH must be >= 1");
    end

    logic                  fire;
    logic                  read_fire;
    logic                  rsp_pop;
    logic [CREDIT_W-1:0]   credits;
    logic [BANK_IDX_W-1:0] req_bank;
    pipe_entry_t           pipe [READ_LATENCY];
    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] fifo_push_data;

    // REQ_READY depends only on the credit register and reset. A FIFO slot
    // freed by a pop becomes usable one cycle later.
    assign REQ_READY = (credits < CREDIT_W'(RSP_DEPTH)) && !RST;
    assign fire      = REQ_VALID && REQ_READY;
    assign read_fire = fire && !REQ_WE;
    assign rsp_pop   = RSP_VALID && RSP_READY;

    // The shift form still gives a defined bank index of 0 when there is
    // only one bank and no bank-select bits exist.
    assign req_bank = BANK_IDX_W'(REQ_ADDR >> BANK_ADDR_WIDTH);

    assign MEM_ADDR = REQ_ADDR[BANK_ADDR_WIDTH-1:0];
    assign MEM_DIN  = REQ_WDATA;

    // Bank decode and bit-mask expansion. All enables and the mask are
    // zero unless a request fires in this cycle.
    always_comb begin
        MEM_MEN = '0;
        MEM_WEN = '0;
        MEM_REN = '0;
        MEM_BM  = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (fire && (req_bank == BANK_IDX_W'(b))) begin
                MEM_MEN[b] = 1'b1;
                MEM_WEN[b] = REQ_WE;
                MEM_REN[b] = !REQ_WE;
            end
        end
        if (fire && REQ_WE) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                MEM_BM[i*8 +: 8] = {8{REQ_BE[i]}};
            end
        end
    end

    // Read-latency pipeline. Stage 0 is loaded at the macro's sampling edge.
    // The last stage lines up with the cycle in which the macro's DOUT is valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= read_fire;
            pipe[0].bank  <= req_bank;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign fifo_push = pipe[READ_LATENCY-1].valid;

    // Pick the DOUT slice of the bank that the finishing read targeted.
    always_comb begin
        fifo_push_data = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (pipe[READ_LATENCY-1].bank == BANK_IDX_W'(b)) begin
                fifo_push_data = MEM_DOUT[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read credits count accepted reads whose responses have not been
    // consumed yet. Writes take no credit because they produce no response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            credits <= '0;
        end else begin
            case ({read_fire, rsp_pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop_ready(RSP_READY),
        .out_valid(RSP_VALID),
        .out_data (RSP_RDATA)
    );

endmodule
